// File: rtl/pipe_pkg.sv
// Shared pipeline control definitions: controller state encoding, register
// address constants and the control word carried by the pipeline registers.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MC_BUSY  = 2'd2
  } state_e;

  localparam int REG_AW   = 4;
  localparam int ZERO_REG = 0;

  // Per-stage control carried down the pipe; a bubble is all zero.
  typedef struct packed {
    logic wb;
    logic mem;
    logic ex;
  } stage_ctrl_t;

  localparam stage_ctrl_t BUBBLE_CTRL = '0;

  // Controller output word, one bit per pipeline-register control.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_bubble;
    logic exmem_en;
    logic exmem_bubble;
    logic memwb_en;
  } ctl_t;

  localparam ctl_t CTL_FREEZE = '0;
  localparam ctl_t CTL_RUN    = '{pc_en:1'b1, ifid_en:1'b1, ifid_flush:1'b0,
                                  idex_en:1'b1, idex_bubble:1'b0,
                                  exmem_en:1'b1, exmem_bubble:1'b0,
                                  memwb_en:1'b1};
  // Front end held, back end drains with bubbles behind the multi-cycle op.
  localparam ctl_t CTL_MC     = '{pc_en:1'b0, ifid_en:1'b0, ifid_flush:1'b0,
                                  idex_en:1'b0, idex_bubble:1'b0,
                                  exmem_en:1'b1, exmem_bubble:1'b1,
                                  memwb_en:1'b1};
  localparam ctl_t CTL_BRANCH = '{pc_en:1'b1, ifid_en:1'b1, ifid_flush:1'b1,
                                  idex_en:1'b1, idex_bubble:1'b1,
                                  exmem_en:1'b1, exmem_bubble:1'b0,
                                  memwb_en:1'b1};
  // Hold PC and IF/ID one cycle, inject a bubble into EX.
  localparam ctl_t CTL_LOADUSE = '{pc_en:1'b0, ifid_en:1'b0, ifid_flush:1'b0,
                                   idex_en:1'b1, idex_bubble:1'b1,
                                   exmem_en:1'b1, exmem_bubble:1'b0,
                                   memwb_en:1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc high, holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  // Count register, cleared by async reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: decodes enables, flushes and bubbles for
// every pipeline register from hazards, memory wait states and multi-cycle ops.
module hazard_ctrl #(
  parameter int REG_AW      = pipe_pkg::REG_AW,
  parameter int CNT_W       = 16,
  parameter int ZERO_REG_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_branch_taken,
  input  logic              mc_start,
  input  logic              mc_done,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_bubble,
  output logic              exmem_en,
  output logic              exmem_bubble,
  output logic              memwb_en,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import pipe_pkg::*;

  state_e state_q, state_d;
  ctl_t   run_ctl, ctl, ctl_out;
  state_e run_next;
  logic   mem_stall, rd_live, rs_hit, rt_hit, load_use;

  // Load-use compare: a load in EX feeding a source read in ID.
  always_comb begin
    rd_live  = (ZERO_REG_EN == 0) || (ex_rd != REG_AW'(ZERO_REG));
    rs_hit   = id_uses_rs && (id_rs == ex_rd);
    rt_hit   = id_uses_rt && (id_rt == ex_rd);
    load_use = ex_memread && rd_live && (rs_hit || rt_hit);
  end

  assign mem_stall = mem_req && !mem_ack;

  // RUN decode with the memory condition treated as clear.
  always_comb begin
    run_ctl  = CTL_RUN;
    run_next = RUN;
    if (mc_start && !mc_done) begin
      run_ctl  = CTL_MC;
      run_next = MC_BUSY;
    end else if (ex_branch_taken) begin
      run_ctl  = CTL_BRANCH;
    end else if (load_use) begin
      run_ctl  = CTL_LOADUSE;
    end
  end

  // Next state and Mealy outputs; memory wait outranks everything.
  always_comb begin
    ctl     = CTL_FREEZE;
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
        end else begin
          ctl     = run_ctl;
          state_d = run_next;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          ctl     = run_ctl;
          state_d = run_next;
        end
      end
      MC_BUSY: begin
        if (mem_stall) begin
          ctl = CTL_FREEZE;
        end else if (mc_done) begin
          ctl     = CTL_RUN;
          state_d = RUN;
        end else begin
          ctl = CTL_MC;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  // Reset forces every control low regardless of the decode.
  always_comb begin
    ctl_out = rst ? ctl : CTL_FREEZE;
  end

  assign pc_en        = ctl_out.pc_en;
  assign ifid_en      = ctl_out.ifid_en;
  assign ifid_flush   = ctl_out.ifid_flush;
  assign idex_en      = ctl_out.idex_en;
  assign idex_bubble  = ctl_out.idex_bubble;
  assign exmem_en     = ctl_out.exmem_en;
  assign exmem_bubble = ctl_out.exmem_bubble;
  assign memwb_en     = ctl_out.memwb_en;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!ctl_out.pc_en && rst),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctl_out.ifid_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus pipeline-aware random
// stimulus, checked every cycle against a behavioural model.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rs = 0, id_uses_rt = 0, ex_memread = 0, ex_branch_taken = 0;
  logic mc_start = 0, mc_done = 0, mem_req = 0, mem_ack = 0;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble, memwb_en;
  logic [15:0] stall_cnt, flush_cnt;
  logic pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_bubble4, exmem_en4, exmem_bubble4, memwb_en4;
  logic [3:0] stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mc_start(mc_start), .mc_done(mc_done),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_bubble(idex_bubble),
    .exmem_en(exmem_en), .exmem_bubble(exmem_bubble), .memwb_en(memwb_en),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_branch_taken(ex_branch_taken), .mc_start(mc_start), .mc_done(mc_done),
    .mem_req(mem_req), .mem_ack(mem_ack), .pc_en(pc_en4), .ifid_en(ifid_en4),
    .ifid_flush(ifid_flush4), .idex_en(idex_en4), .idex_bubble(idex_bubble4),
    .exmem_en(exmem_en4), .exmem_bubble(exmem_bubble4), .memwb_en(memwb_en4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4));

  wire [7:0] d_o  = {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, exmem_bubble, memwb_en};
  wire [7:0] d4_o = {pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_bubble4, exmem_en4, exmem_bubble4, memwb_en4};

  // Control words, bit order {pc, ifid, flush, idex, idex_bub, exmem, exmem_bub, memwb}.
  localparam logic [7:0] ALL_EN  = 8'b1101_0101;
  localparam logic [7:0] FROZEN  = 8'b0000_0000;
  localparam logic [7:0] MC_HOLD = 8'b0000_0111;
  localparam logic [7:0] BR      = 8'b1111_1101;
  localparam logic [7:0] LU      = 8'b0001_1101;

  int total = 0;
  int bad   = 0;

  // Model: the pipe is waiting on memory, or busy behind a multi-cycle op.
  bit waiting_mem, busy_mc;
  logic [7:0] m_o, prev_o, s_o;
  int m_stall, m_flush, m_stall4, m_flush4;

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] normal_flow();
    bit hit;
    hit = ex_memread && (ex_rd != 0) &&
          ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
    if (mc_start && !mc_done) return MC_HOLD;
    if (ex_branch_taken)      return BR;
    if (hit)                  return LU;
    return ALL_EN;
  endfunction

  function automatic logic [7:0] expected();
    bit mem_blocked = mem_req && !mem_ack;
    if (!rst)        return FROZEN;
    if (busy_mc)     return mem_blocked ? FROZEN : (mc_done ? ALL_EN : MC_HOLD);
    if (waiting_mem) return mem_ack ? normal_flow() : FROZEN;
    return mem_blocked ? FROZEN : normal_flow();
  endfunction

  task automatic model_reset();
    waiting_mem = 0; busy_mc = 0;
    m_stall = 0; m_flush = 0; m_stall4 = 0; m_flush4 = 0;
    prev_o = ALL_EN;
  endtask

  // One cycle: inputs already driven after the falling edge; compare, advance model.
  task automatic step();
    bit mem_blocked;
    #1;
    if (!rst) model_reset();
    m_o = expected();
    s_o = d_o;
    cmp("ctl", d_o, m_o);
    cmp("ctl_w4", d4_o, m_o);
    cmp("stall_cnt", stall_cnt, m_stall);
    cmp("flush_cnt", flush_cnt, m_flush);
    cmp("stall_cnt_w4", stall_cnt4, m_stall4);
    cmp("flush_cnt_w4", flush_cnt4, m_flush4);
    if (rst) begin
      mem_blocked = mem_req && !mem_ack;
      if (busy_mc) begin
        if (!mem_blocked && mc_done) busy_mc = 0;
      end else if (waiting_mem) begin
        if (mem_ack) begin
          waiting_mem = 0;
          busy_mc = mc_start && !mc_done;
        end
      end else if (mem_blocked) begin
        waiting_mem = 1;
      end else begin
        busy_mc = mc_start && !mc_done;
      end
      if (!m_o[7]) begin
        if (m_stall < 65535) m_stall++;
        if (m_stall4 < 15)   m_stall4++;
      end
      if (m_o[5]) begin
        if (m_flush < 65535) m_flush++;
        if (m_flush4 < 15)   m_flush4++;
      end
      prev_o = m_o;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    id_rs = 0; id_rt = 0; ex_rd = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_memread = 0; ex_branch_taken = 0; mc_start = 0; mc_done = 0;
    mem_req = 0; mem_ack = 0;
  endtask

  task automatic do_reset();
    quiet();
    rst = 0;
    step();
    rst = 1;
  endtask

  // Random inputs that respect what a real pipe can present next cycle.
  task automatic rand_inputs();
    bit was_blocked = mem_req && !mem_ack;
    if (prev_o[4]) begin
      if (prev_o[3]) begin
        ex_memread = 0; ex_branch_taken = 0; mc_start = 0;
        ex_rd = 4'($urandom_range(0, 7));
      end else begin
        ex_rd           = 4'($urandom_range(0, 7));
        ex_memread      = ($urandom_range(0, 99) < 30);
        ex_branch_taken = ($urandom_range(0, 99) < 15);
        mc_start        = ($urandom_range(0, 99) < 10);
      end
    end
    if (prev_o[6]) begin
      id_rs = 4'($urandom_range(0, 7));
      id_rt = 4'($urandom_range(0, 7));
      id_uses_rs = !prev_o[5] && ($urandom_range(0, 99) < 70);
      id_uses_rt = !prev_o[5] && ($urandom_range(0, 99) < 70);
    end
    mem_req = was_blocked ? 1'b1 : ($urandom_range(0, 99) < 25);
    mem_ack = mem_req && ($urandom_range(0, 99) < 40);
    mc_done = busy_mc ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 5);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();
    cmp("reset_ctl", s_o, FROZEN);

    // Load-use on rs: one stall cycle, then free flow.
    quiet(); ex_memread = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    step();
    cmp("lu_ctl", s_o, LU);
    quiet();
    step();
    cmp("lu_after", s_o, ALL_EN);
    cmp("lu_stall_cnt", stall_cnt, 1);

    // Register zero never hazards.
    do_reset();
    ex_memread = 1; ex_rd = 0; id_rs = 0; id_uses_rs = 1;
    step();
    cmp("zero_ctl", s_o, ALL_EN);
    cmp("zero_stall_cnt", stall_cnt, 0);

    // Branch beats load-use.
    do_reset();
    ex_branch_taken = 1; ex_memread = 1; ex_rd = 5; id_rs = 5; id_uses_rs = 1;
    step();
    cmp("br_ctl", s_o, BR);
    cmp("br_flush_cnt", flush_cnt, 1);
    cmp("br_stall_cnt", stall_cnt, 0);

    // Memory wait: three frozen cycles then the ack cycle flows.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem_req = 1; mem_ack = 0;
      step();
      cmp("memw_ctl", s_o, FROZEN);
    end
    mem_ack = 1;
    step();
    cmp("memw_ack_ctl", s_o, ALL_EN);
    cmp("memw_stall_cnt", stall_cnt, 3);

    // Multi-cycle op: four drain cycles, then done.
    do_reset();
    mc_start = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      cmp("mc_ctl", s_o, MC_HOLD);
    end
    mc_done = 1;
    step();
    cmp("mc_done_ctl", s_o, ALL_EN);
    cmp("mc_stall_cnt", stall_cnt, 4);

    // Reset while busy on a multi-cycle op with ten stalls counted.
    do_reset();
    mc_start = 1;
    for (int i = 0; i < 10; i++) step();
    cmp("pre_rst_stall_cnt", stall_cnt, 10);
    rst = 0;
    #1;
    cmp("rst_mid_ctl", d_o, FROZEN);
    cmp("rst_mid_stall_cnt", stall_cnt, 0);
    cmp("rst_mid_flush_cnt", flush_cnt, 0);
    model_reset();
    @(negedge clk);
    rst = 1; quiet();
    step();
    cmp("rst_release_ctl", s_o, ALL_EN);

    // Saturation on the narrow counter.
    do_reset();
    mc_start = 1;
    for (int i = 0; i < 20; i++) step();
    cmp("sat_stall_cnt_w4", stall_cnt4, 15);
    cmp("sat_stall_cnt", stall_cnt, 20);
    mc_done = 1;
    step();

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
